// File: rtl/hv_stream_packer.sv
// hv_stream_packer: captures 1024-bit hypervectors from a strobe-only upstream
// into a 2-entry ping-pong store and streams them out as OUT_W-bit AXI4-Stream
// beats, LSB word first, with job-level tlast and a sticky drop flag.
module hv_stream_packer #(
    parameter  int HV_W  = 1024,
    parameter  int OUT_W = 64,
    localparam int BEATS = HV_W / OUT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [15:0]      i_cfg_num_hv,
    input  logic             i_clr_err,
    input  logic             i_hv_valid,
    input  logic [HV_W-1:0]  i_hv_data,
    output logic [OUT_W-1:0] o_m_axis_tdata,
    output logic             o_m_axis_tvalid,
    input  logic             i_m_axis_tready,
    output logic             o_m_axis_tlast,
    output logic             o_overflow,
    output logic             o_busy
);

    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [HV_W-1:0]   r_slot [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_occ;
    logic [BW-1:0]     r_beat;
    logic              r_busy;
    logic [15:0]       r_hv_idx;
    logic [15:0]       r_cfg_num;
    logic              r_overflow;
    logic              r_tvalid;
    logic              r_tlast;
    logic [OUT_W-1:0]  r_tdata;

    logic              w_fire;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [1:0]        w_occ_after_pop;
    logic [1:0]        w_occ_next;
    logic              w_rd_ptr_next;
    logic [BW-1:0]     w_beat_next;
    logic              w_busy_next;
    logic [15:0]       w_hv_idx_next;
    logic [15:0]       w_cfg_next;
    logic [15:0]       w_cfg_max_next;
    logic              w_tlast_next;
    logic [HV_W-1:0]   w_src_vec;
    logic [OUT_W-1:0]  w_words [BEATS];
    logic [OUT_W-1:0]  w_tdata_next;

    // A pop is acceptance of the final beat of the vector at the read side.
    // A full store still takes a new vector when a pop frees a slot this cycle.
    assign w_fire          = r_tvalid & i_m_axis_tready;
    assign w_pop           = w_fire & (r_beat == BW'(BEATS - 1));
    assign w_push          = i_hv_valid & ((r_occ != 2'd2) | w_pop);
    assign w_drop          = i_hv_valid & (r_occ == 2'd2) & ~w_pop;
    assign w_occ_after_pop = r_occ - {1'b0, w_pop};
    assign w_occ_next      = w_occ_after_pop + {1'b0, w_push};
    assign w_rd_ptr_next   = r_rd_ptr ^ w_pop;
    assign w_beat_next     = w_pop ? '0 : (w_fire ? r_beat + 1'b1 : r_beat);

    // When nothing remains stored after this cycle's pop, the vector to send
    // next is the one arriving right now, so bypass the slot write.
    assign w_src_vec = (w_occ_after_pop == 2'd0) ? i_hv_data : r_slot[w_rd_ptr_next];

    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_words
            assign w_words[gi] = w_src_vec[gi*OUT_W +: OUT_W];
        end
    endgenerate

    assign w_tdata_next = w_words[w_beat_next];

    // Next state: leave IDLE on any pending vector, leave SEND only when drained.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if ((r_occ != 2'd0) || w_push) w_state_next = ST_SEND;
            ST_SEND: if (w_pop && (w_occ_after_pop == 2'd0) && !w_push) w_state_next = ST_IDLE;
        endcase
    end

    // Job accounting: start restarts the count, the tlast beat ends the job.
    always_comb begin
        w_busy_next   = r_busy;
        w_hv_idx_next = r_hv_idx;
        w_cfg_next    = r_cfg_num;
        if (i_start) begin
            w_busy_next   = 1'b1;
            w_hv_idx_next = '0;
            w_cfg_next    = i_cfg_num_hv;
        end else if (w_fire && r_tlast) begin
            w_busy_next   = 1'b0;
            w_hv_idx_next = '0;
        end else if (w_pop && r_busy) begin
            w_hv_idx_next = r_hv_idx + 16'd1;
        end
        w_cfg_max_next = (w_cfg_next == 16'd0) ? 16'd1 : w_cfg_next;
        w_tlast_next   = (w_state_next == ST_SEND) && (w_beat_next == BW'(BEATS - 1))
                         && w_busy_next && (w_hv_idx_next == (w_cfg_max_next - 16'd1));
    end

    // Slot storage is data-only and deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (w_push) r_slot[r_wr_ptr] <= i_hv_data;
    end

    // Control state and registered stream outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_occ      <= 2'd0;
            r_beat     <= '0;
            r_busy     <= 1'b0;
            r_hv_idx   <= '0;
            r_cfg_num  <= '0;
            r_overflow <= 1'b0;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_tdata    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wr_ptr   <= r_wr_ptr ^ w_push;
            r_rd_ptr   <= w_rd_ptr_next;
            r_occ      <= w_occ_next;
            r_beat     <= w_beat_next;
            r_busy     <= w_busy_next;
            r_hv_idx   <= w_hv_idx_next;
            r_cfg_num  <= w_cfg_next;
            r_tvalid   <= (w_state_next == ST_SEND);
            r_tlast    <= w_tlast_next;
            r_tdata    <= (w_state_next == ST_SEND) ? w_tdata_next : '0;
            if (w_drop) r_overflow <= 1'b1;
            else if (i_clr_err) r_overflow <= 1'b0;
        end
    end

    assign o_m_axis_tdata  = r_tdata;
    assign o_m_axis_tvalid = r_tvalid;
    assign o_m_axis_tlast  = r_tlast;
    assign o_overflow      = r_overflow;
    assign o_busy          = r_busy;

endmodule

// File: tb/tb_hv_stream_packer.sv
// Self-checking bench for hv_stream_packer: a queue-of-vectors reference model
// predicts every cycle's outputs; directed scenarios plus a random phase.
module tb_hv_stream_packer;

    localparam int HV_W  = 1024;
    localparam int OUT_W = 64;
    localparam int BEATS = HV_W / OUT_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [15:0]      cfg = '0;
    logic             clr_err = 1'b0;
    logic             hv_valid = 1'b0;
    logic [HV_W-1:0]  hv_data = '0;
    logic             tready = 1'b0;
    logic [OUT_W-1:0] tdata;
    logic             tvalid;
    logic             tlast;
    logic             overflow;
    logic             busy;

    hv_stream_packer #(.HV_W(HV_W), .OUT_W(OUT_W)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .i_cfg_num_hv    (cfg),
        .i_clr_err       (clr_err),
        .i_hv_valid      (hv_valid),
        .i_hv_data       (hv_data),
        .o_m_axis_tdata  (tdata),
        .o_m_axis_tvalid (tvalid),
        .i_m_axis_tready (tready),
        .o_m_axis_tlast  (tlast),
        .o_overflow      (overflow),
        .o_busy          (busy)
    );

    always #5 clk = ~clk;

    // Reference model: vectors not yet fully sent, beat index of the head,
    // job state and sticky overflow.
    logic [HV_W-1:0] mq [$];
    int  mbeat, mdone, mcfg;
    bit  mbusy, movf;

    int n_checks = 0, n_fail = 0;
    int fire_cnt, last_cnt, cyc, first_v, last_v;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int cfg_max();
        return (mcfg == 0) ? 1 : mcfg;
    endfunction

    function automatic logic [HV_W-1:0] rand_hv();
        logic [HV_W-1:0] v;
        for (int i = 0; i < HV_W / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic model_reset();
        mq.delete();
        mbeat = 0; mdone = 0; mcfg = 0; mbusy = 0; movf = 0;
    endtask

    task automatic reset_counts();
        fire_cnt = 0; last_cnt = 0; first_v = -1; last_v = -1;
    endtask

    task automatic check_outputs();
        logic [HV_W-1:0] v;
        bit exp_v;
        exp_v = (mq.size() > 0);
        chk("tvalid", tvalid, exp_v);
        chk("busy", busy, mbusy);
        chk("overflow", overflow, movf);
        if (exp_v) begin
            v = mq[0];
            chk("tdata", tdata, v[mbeat*OUT_W +: OUT_W]);
            chk("tlast", tlast, mbusy && (mbeat == BEATS - 1) && (mdone == cfg_max() - 1));
        end else begin
            chk("tlast_idle", tlast, 0);
        end
    endtask

    task automatic model_step();
        bit fire, pop, tl, push, drop;
        int sz;
        sz   = mq.size();
        fire = (sz > 0) && tready;
        pop  = fire && (mbeat == BEATS - 1);
        tl   = pop && mbusy && (mdone == cfg_max() - 1);
        push = hv_valid && ((sz < 2) || pop);
        drop = hv_valid && (sz == 2) && !pop;
        if (fire) mbeat = pop ? 0 : mbeat + 1;
        if (start) begin
            mbusy = 1; mcfg = cfg; mdone = 0;
        end else if (tl) begin
            mbusy = 0; mdone = 0;
        end else if (pop && mbusy) begin
            mdone++;
        end
        if (pop) mq.delete(0);
        if (push) mq.push_back(hv_data);
        if (drop) movf = 1;
        else if (clr_err) movf = 0;
    endtask

    // One clock: check the DUT against the model, record DUT handshakes,
    // advance the model, then clear the one-cycle strobes.
    task automatic cycle();
        check_outputs();
        if (tvalid && tready) fire_cnt++;
        if (tvalid && tready && tlast) last_cnt++;
        if (tvalid) begin
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
        end
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        start = 0; hv_valid = 0; clr_err = 0;
    endtask

    task automatic send_vec(input logic [HV_W-1:0] v);
        hv_valid = 1; hv_data = v;
        cycle();
    endtask

    task automatic pulse_start(input logic [15:0] n);
        start = 1; cfg = n;
        cycle();
    endtask

    task automatic drain(input int bound);
        int k = 0;
        while (mq.size() > 0 && k < bound) begin
            cycle();
            k++;
        end
        chk("drained", tvalid, 0);
    endtask

    initial begin
        logic [HV_W-1:0] v;
        logic [OUT_W-1:0] hold;
        logic [3:0] nib;
        int k;

        cyc = 0;
        model_reset();
        reset_counts();
        repeat (3) @(negedge clk);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1;
        cycle();

        // Single vector with word k = nibble k replicated.
        pulse_start(16'd1);
        for (int w = 0; w < BEATS; w++) begin
            nib = w[3:0];
            v[w*OUT_W +: OUT_W] = {16{nib}};
        end
        tready = 1;
        reset_counts();
        send_vec(v);
        chk("t1_tvalid_next", tvalid, 1);
        chk("t1_beat0", tdata, 64'h0);
        drain(40);
        chk("t1_beats", fire_cnt, 16);
        chk("t1_tlast_cnt", last_cnt, 1);
        chk("t1_busy_low", busy, 0);

        // Backpressure at beat 3 for 5 cycles, then toggled ready.
        pulse_start(16'd1);
        reset_counts();
        send_vec(rand_hv());
        k = 0;
        while (mbeat != 3 && k < 20) begin cycle(); k++; end
        tready = 0;
        hold = tdata;
        repeat (5) begin
            cycle();
            chk("t2_stall_hold", tdata, hold);
        end
        k = 0;
        while (mq.size() > 0 && k < 60) begin
            tready = ~tready;
            cycle();
            k++;
        end
        tready = 1;
        chk("t2_beats", fire_cnt, 16);
        chk("t2_tlast_cnt", last_cnt, 1);

        // Back-to-back job of 3 vectors spaced 16 cycles apart.
        pulse_start(16'd3);
        reset_counts();
        for (int i = 0; i < 3; i++) begin
            send_vec(rand_hv());
            repeat (BEATS - 1) cycle();
        end
        drain(40);
        chk("t3_beats", fire_cnt, 48);
        chk("t3_tlast_cnt", last_cnt, 1);
        chk("t3_no_gap_span", last_v - first_v + 1, 48);

        // Overflow: three vectors into a stalled store.
        tready = 0;
        pulse_start(16'd2);
        reset_counts();
        for (int i = 0; i < 3; i++) send_vec(rand_hv());
        chk("t4_ovf_set", overflow, 1);
        tready = 1;
        drain(60);
        chk("t4_beats", fire_cnt, 32);
        chk("t4_tlast_cnt", last_cnt, 1);
        clr_err = 1;
        cycle();
        chk("t4_ovf_clr", overflow, 0);
        tready = 0;
        send_vec(rand_hv());
        send_vec(rand_hv());
        clr_err = 1;
        send_vec(rand_hv());
        chk("t4_set_wins", overflow, 1);
        clr_err = 1;
        cycle();
        tready = 1;
        drain(60);

        // Full store and pop in the same cycle as a new vector.
        pulse_start(16'd3);
        reset_counts();
        send_vec(rand_hv());
        send_vec(rand_hv());
        k = 0;
        while (mbeat != BEATS - 1 && k < 20) begin cycle(); k++; end
        send_vec(rand_hv());
        chk("t5_no_ovf", overflow, 0);
        drain(60);
        chk("t5_beats", fire_cnt, 48);
        chk("t5_tlast_cnt", last_cnt, 1);

        // Asynchronous reset in the middle of a vector.
        pulse_start(16'd1);
        send_vec(rand_hv());
        k = 0;
        while (mbeat != 7 && k < 20) begin cycle(); k++; end
        #2 rst_n = 0;
        #1;
        chk("t6_rst_tvalid", tvalid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_tlast", tlast, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        pulse_start(16'd1);
        reset_counts();
        send_vec(rand_hv());
        chk("t6_restart_beat0", tvalid, 1);
        drain(40);
        chk("t6_beats", fire_cnt, 16);
        chk("t6_tlast_cnt", last_cnt, 1);

        // Random traffic, ready, starts and clears against the model.
        repeat (400) begin
            hv_valid = ($urandom_range(0, 9) == 0);
            hv_data  = rand_hv();
            tready   = ($urandom_range(0, 3) != 0);
            start    = ($urandom_range(0, 60) == 0);
            cfg      = 16'($urandom_range(0, 3));
            clr_err  = ($urandom_range(0, 30) == 0);
            cycle();
        end
        tready = 1;
        drain(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hv_stream_packer.md
Name: hv_stream_packer

Overview:
- Downstream neighbour of the sign-bit buffer stage.
- Captures each 1024-bit encoded hypervector that stage presents on its one-cycle valid strobe, then serialises it as OUT_W-bit beats on an AXI4-Stream master towards the DMA.
- Provides a 2-entry ping-pong store. The upstream stage has no backpressure, so vectors that arrive while both entries are full are dropped and flagged.
- Asserts tlast on the final beat of the final hypervector of a job of cfg_num_hv vectors.

Parameters:
- HV_W, 1024, hypervector width in bits.
- OUT_W, 64, AXI-Stream data width. HV_W must be an integer multiple of OUT_W.
- BEATS, HV_W/OUT_W (16), beats per hypervector. Derived; do not override.

Ports:
- clk  in  1  Single clock. All logic on posedge.
- rst  in  1  Asynchronous, active-low reset.
- start  in  1  One-cycle pulse. Loads cfg_num_hv, clears hv_idx, and begins a job.
- cfg_num_hv  in  16  Hypervectors per job. A value of 0 is treated as 1.
- clr_err  in  1  Clears the sticky overflow flag.
- hv_valid  in  1  One-cycle strobe. hv_data is a complete vector.
- hv_data  in  HV_W  Sign-bit hypervector.
- m_axis_tdata  out  OUT_W  Output beat.
- m_axis_tvalid  out  1  Beat valid.
- m_axis_tready  in  1  Sink ready.
- m_axis_tlast  out  1  Last beat of the job.
- overflow  out  1  Sticky: a vector was dropped.
- busy  out  1  High from start until the job's tlast beat is accepted.

Behaviour:
- Reset values, asserted asynchronously: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, overflow=0, busy=0. Pointers, occupancy, beat counter and hv_idx are all 0. Slot contents are don't-care and are not reset.
- Storage:
  - 2 slots of HV_W bits, with wr_ptr, rd_ptr and occ (0..2).
  - A push writes slot[wr_ptr] and toggles wr_ptr.
  - A pop happens when the last beat of a slot is accepted; it toggles rd_ptr.
- Push rules:
  - hv_valid with occ<2 → push.
  - hv_valid with occ==2 and no same-cycle pop → vector dropped, overflow<=1.
  - hv_valid with occ==2 and a same-cycle pop → push accepted, no overflow, occ stays 2.
  - hv_valid while busy==0 → still stored (no gating). hv_idx counts only while busy.
- Output FSM, states IDLE and SEND:
  - IDLE→SEND when occ>0 or a push is occurring. Registered output: hv_valid at cycle N into an empty block gives tvalid=1 at N+1 with beat 0.
  - SEND: tdata = slot[rd_ptr][beat*OUT_W +: OUT_W], LSB word first (beat 0 = bits [OUT_W-1:0]).
  - Beat advances only on tvalid&&tready.
  - While tvalid&&!tready, tdata, tvalid and tlast hold stable (AXI rule).
  - After the last beat (beat==BEATS-1) is accepted: pop, beat<=0. Stay in SEND if occ after pop >0, or if a push occurs in the same cycle, so there is no bubble between back-to-back vectors. Otherwise go to IDLE and deassert tvalid.
- Job accounting:
  - hv_idx increments on each pop while busy.
  - tlast=1 exactly on beat BEATS-1 when busy and hv_idx==max(cfg_num_hv,1)-1.
  - On acceptance of that beat: busy<=0, hv_idx<=0.
  - Pops while busy==0 give tlast=0.
- start:
  - start while busy → restarts the count, hv_idx<=0, and reloads cfg.
  - Slot contents and any in-flight beat are kept, not flushed.
- clr_err and a new overflow in the same cycle → overflow=1 (set wins).
- Throughput: sustains 1 vector per BEATS cycles with tready held at 1. A faster upstream rate overflows after 2 buffered vectors.
- A reset asserted mid-beat returns everything to the reset values immediately. Stored data is discarded.

Test Plan:
- Single vector, cfg_num_hv=1, tready=1. Inject hv_data={16 words 0x0..0xF}, i.e. word k = k replicated to 64 bits. Require: tvalid from the next cycle; 16 consecutive beats with tdata=word 0..15 in order; tlast only on beat 15; busy falls after it.
- Backpressure: hold tready=0 for 5 cycles at beat 3, then toggle it every cycle. Require: tdata stable while stalled, no beat skipped or duplicated, 16 beats total.
- Back-to-back: cfg_num_hv=3, 3 vectors spaced 16 cycles apart, tready=1. Require: 48 contiguous beats with no tvalid gap, and tlast only on beat 47.
- Overflow: tready=0, inject 3 vectors. Require: overflow=1 after the 3rd and the first 2 vectors output intact. Then pulse clr_err: overflow=0. Simultaneous clr_err and a new drop: overflow stays 1.
- Full and pop collide: occ=2, hv_valid in the same cycle the last beat is accepted. Require: no overflow, and the new vector is emitted after the remaining one.
- Async reset asserted mid-transfer at beat 7, with no clk edge. Require: tvalid=0 and busy=0 immediately. After release, a new vector streams from beat 0.
